sh_chain_loader: RTL and testbench

Parallel-to-serial loader that drives a configuration shift chain built from `sh_dff` cells. It accepts words over a valid/ready interface and shifts them LSB-first onto the chain's serial data line, framing every `CHAIN_LEN` bits. At each frame end it issues a one-cycle capture strobe to commit the chain contents. It is the writer side of the shift-chain interface and sits between the configuration controller's word stream and the fabric scan chain.

---
 rtl/sh_chain_loader.sv | 160 ++++++++++++++++
 tb/tb_sh_chain_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sh_chain_loader.sv
// Word-to-serial loader for an sh_dff configuration chain; emits se/sd LSB-first and an ld strobe per frame.
// Latency: word accepted in cycle t -> first se in cycle t+2; one word of buffering; din_ready = hold register empty.
// Optional SH_CHAIN_LOADER_PARITY_EN adds one parity bit (se=1) after each frame, before ld.
module sh_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 64
) (
    input  logic              C,
    input  logic              R,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sd,
    output logic              se,
    output logic              ld,
    output logic              busy
);

    localparam int BW = $clog2(WORD_W);
    localparam int FW = $clog2(CHAIN_LEN);
    localparam logic [BW-1:0] BLAST = BW'(WORD_W - 1);
    localparam logic [FW-1:0] FLAST = FW'(CHAIN_LEN - 1);

`ifdef SH_CHAIN_LOADER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
`endif

    state_t              state;
    logic [WORD_W-1:0]   hold;
    logic                hold_valid;
    logic [WORD_W-1:0]   shreg;
    logic [BW-1:0]       bitcnt;
    logic [FW-1:0]       framecnt;
    logic                last_bit;
    logic                last_frame;
    logic                take;
`ifdef SH_CHAIN_LOADER_PARITY_EN
    logic                par;
`endif

    assign last_bit   = (bitcnt == BLAST);
    assign last_frame = (framecnt == FLAST);
    assign din_ready  = !hold_valid;
    assign busy       = (state != IDLE);

`ifdef SH_CHAIN_LOADER_PARITY_EN
    assign sd = se & ((state == PARITY) ? par : shreg[0]);
`else
    assign sd = se & shreg[0];
`endif

    // Hold register drains into shreg at frame start, at a word boundary, or to end a stall.
    always_comb begin
        take = 1'b0;
        if (hold_valid) begin
            case (state)
                IDLE, LOAD: take = 1'b1;
                SHIFT:      take = !se || (last_bit && !last_frame);
                default:    take = 1'b0;
            endcase
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shreg      <= '0;
            bitcnt     <= '0;
            framecnt   <= '0;
            se         <= 1'b0;
            ld         <= 1'b0;
`ifdef SH_CHAIN_LOADER_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            ld <= 1'b0;

            // No bypass: din_ready is low the whole cycle the hold register drains.
            if (take) begin
                hold_valid <= 1'b0;
            end else if (din_valid && !hold_valid) begin
                hold       <= din;
                hold_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (hold_valid) begin
                        state    <= SHIFT;
                        framecnt <= '0;
`ifdef SH_CHAIN_LOADER_PARITY_EN
                        par      <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (se) begin
                        shreg    <= shreg >> 1;
                        bitcnt   <= bitcnt + 1'b1;
                        framecnt <= framecnt + 1'b1;
`ifdef SH_CHAIN_LOADER_PARITY_EN
                        par      <= par ^ shreg[0];
`endif
                        if (last_frame) begin
                            bitcnt   <= '0;
                            framecnt <= '0;
`ifdef SH_CHAIN_LOADER_PARITY_EN
                            state    <= PARITY;
                            se       <= 1'b1;
`else
                            state    <= LOAD;
                            se       <= 1'b0;
                            ld       <= 1'b1;
`endif
                        end else if (last_bit) begin
                            // Word exhausted mid-frame: continue if a word waits, else stall.
                            bitcnt <= '0;
                            se     <= hold_valid;
                        end
                    end
                end
`ifdef SH_CHAIN_LOADER_PARITY_EN
                PARITY: begin
                    state <= LOAD;
                    se    <= 1'b0;
                    ld    <= 1'b1;
                end
`endif
                LOAD: begin
                    se <= 1'b0;
                    if (hold_valid) begin
                        state    <= SHIFT;
                        framecnt <= '0;
`ifdef SH_CHAIN_LOADER_PARITY_EN
                        par      <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    se    <= 1'b0;
                end
            endcase

            // Reloads override the shift above; they always start a fresh word with se high.
            if (take) begin
                shreg  <= hold;
                bitcnt <= '0;
                se     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sh_chain_loader.sv
// Directed bench for sh_chain_loader with WORD_W=8, CHAIN_LEN=16.
module tb_sh_chain_loader;

    localparam int WW = 8;
    localparam int CL = 16;
`ifdef SH_CHAIN_LOADER_PARITY_EN
    localparam int FL = CL + 1;
`else
    localparam int FL = CL;
`endif

    logic          C = 1'b0;
    logic          R = 1'b0;
    logic [WW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready, sd, se, ld, busy;

    int checks = 0;
    int passed = 0;

    logic se_h[$];
    logic ld_h[$];
    logic sd_h[$];
    int   acc_cyc;

    sh_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
        .C(C), .R(R), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sd(sd), .se(se), .ld(ld), .busy(busy)
    );

    always #5 C = ~C;

    // Feeds up to four words (g0 idle cycles after the first), recording outputs each cycle.
    task automatic run(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                       input logic [7:0] w3, input int nw, input int g0, input int ncyc,
                       input int stop_se);
        logic [7:0] ws[4];
        int k, gap, nse;
        logic wa;
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        k = 0; gap = 0; nse = 0;
        se_h.delete(); ld_h.delete(); sd_h.delete();
        acc_cyc = -1;
        @(posedge C); #1;
        din = ws[0];
        din_valid = (nw > 0);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge C);
            se_h.push_back(se); ld_h.push_back(ld); sd_h.push_back(sd);
            if (se) nse++;
            wa = din_valid && din_ready;
            if (wa && k == 0) acc_cyc = c;
            if (stop_se > 0 && nse == stop_se) begin
                din_valid = 1'b0;
                return;
            end
            @(posedge C); #1;
            if (wa) begin
                k++;
                din_valid = 1'b0;
                gap = (k == 1) ? g0 : 0;
            end
            if (!din_valid && k < nw) begin
                if (gap == 0) begin
                    din = ws[k];
                    din_valid = 1'b1;
                end else begin
                    gap--;
                end
            end
        end
        din_valid = 1'b0;
    endtask

    function automatic int first_se();
        for (int i = 0; i < se_h.size(); i++)
            if (se_h[i]) return i;
        return -1;
    endfunction

    function automatic int count_ld();
        int n = 0;
        for (int i = 0; i < ld_h.size(); i++) if (ld_h[i]) n++;
        return n;
    endfunction

    function automatic int count_overlap();
        int n = 0;
        for (int i = 0; i < ld_h.size(); i++) if (ld_h[i] && se_h[i]) n++;
        return n;
    endfunction

    function automatic int count_se(input int from, input int len);
        int n = 0;
        for (int i = from; i < from + len && i < se_h.size(); i++) if (se_h[i]) n++;
        return n;
    endfunction

    function automatic logic [15:0] frame_bits(input int from);
        logic [15:0] b = '0;
        for (int i = 0; i < 16 && from + i < sd_h.size(); i++) b[i] = sd_h[from + i];
        return b;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge C);
        checks++;
        if ({din_ready, se, sd, ld, busy} !== 5'b10000) begin
            $display("FAIL reset_hold: got %b expected 10000", {din_ready, se, sd, ld, busy});
        end else passed++;
        R = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge C);
            checks++;
            if ({din_ready, se, sd, ld, busy} !== 5'b10000) begin
                $display("FAIL idle_cycle%0d: got %b expected 10000", i, {din_ready, se, sd, ld, busy});
            end else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int f;
        run(8'hA5, 8'h3C, 8'h00, 8'h00, 2, 0, 40, 0);
        f = first_se();
        checks++;
        if (f - acc_cyc !== 2) $display("FAIL b2b_latency: got %0d expected 2", f - acc_cyc);
        else passed++;
        checks++;
        if (f < 0 || count_se(f, FL) !== FL) $display("FAIL b2b_se_run: got %0d expected %0d", count_se(f, FL), FL);
        else passed++;
        checks++;
        if (f < 0 || frame_bits(f) !== 16'h3CA5) $display("FAIL b2b_bits: got %h expected 3ca5", frame_bits(f));
        else passed++;
        checks++;
        if (f < 0 || ld_h[f + FL] !== 1'b1) $display("FAIL b2b_ld_pos: got %b expected 1", (f < 0) ? 1'bx : ld_h[f + FL]);
        else passed++;
        checks++;
        if (count_ld() !== 1) $display("FAIL b2b_ld_count: got %0d expected 1", count_ld());
        else passed++;
        checks++;
        if (count_overlap() !== 0) $display("FAIL b2b_ld_se_overlap: got %0d expected 0", count_overlap());
        else passed++;
    endtask

    task automatic test_stall();
        int f, last, nbit, stall;
        logic [15:0] b;
        run(8'h96, 8'h0F, 8'h00, 8'h00, 2, 12, 50, 0);
        f = first_se();
        b = '0; nbit = 0; last = -1;
        for (int i = 0; i < se_h.size(); i++) begin
            if (se_h[i] && nbit < 16) begin
                b[nbit] = sd_h[i];
                nbit++;
                last = i;
            end
        end
        stall = 0;
        for (int i = f; i >= 0 && i <= last; i++) if (!se_h[i]) stall++;
        checks++;
        if (b !== 16'h0F96) $display("FAIL stall_bits: got %h expected 0f96", b);
        else passed++;
        checks++;
        if (stall !== 5) $display("FAIL stall_cycles: got %0d expected 5", stall);
        else passed++;
        checks++;
        if (count_ld() !== 1) $display("FAIL stall_ld_count: got %0d expected 1", count_ld());
        else passed++;
    endtask

    task automatic test_reset_midframe();
        int f;
        run(8'hA5, 8'h3C, 8'h00, 8'h00, 2, 0, 40, 6);
        checks++;
        if (count_ld() !== 0) $display("FAIL midrst_early_ld: got %0d expected 0", count_ld());
        else passed++;
        #1 R = 1'b0;
        #1;
        checks++;
        if ({din_ready, se, sd, ld, busy} !== 5'b10000) begin
            $display("FAIL midrst_outputs: got %b expected 10000", {din_ready, se, sd, ld, busy});
        end else passed++;
        @(negedge C);
        checks++;
        if (ld !== 1'b0) $display("FAIL midrst_ld: got %b expected 0", ld);
        else passed++;
        R = 1'b1;
        run(8'h5A, 8'hC3, 8'h00, 8'h00, 2, 0, 40, 0);
        f = first_se();
        checks++;
        if (f < 0 || frame_bits(f) !== 16'hC35A) $display("FAIL midrst_next_bits: got %h expected c35a", frame_bits(f));
        else passed++;
        checks++;
        if (count_ld() !== 1) $display("FAIL midrst_next_ld: got %0d expected 1", count_ld());
        else passed++;
    endtask

    task automatic test_stream();
        int f;
        run(8'h12, 8'h34, 8'h56, 8'h78, 4, 0, 60, 0);
        f = first_se();
        checks++;
        if (f < 0 || count_se(f, FL) !== FL) $display("FAIL stream_f1_run: got %0d expected %0d", count_se(f, FL), FL);
        else passed++;
        checks++;
        if (f < 0 || frame_bits(f) !== 16'h3412) $display("FAIL stream_f1_bits: got %h expected 3412", frame_bits(f));
        else passed++;
        checks++;
        if (f < 0 || ld_h[f + FL] !== 1'b1) $display("FAIL stream_ld1_pos: got %b expected 1", (f < 0) ? 1'bx : ld_h[f + FL]);
        else passed++;
        checks++;
        if (f < 0 || count_se(f + FL + 1, FL) !== FL) $display("FAIL stream_f2_run: got %0d expected %0d", count_se(f + FL + 1, FL), FL);
        else passed++;
        checks++;
        if (f < 0 || frame_bits(f + FL + 1) !== 16'h7856) $display("FAIL stream_f2_bits: got %h expected 7856", frame_bits(f + FL + 1));
        else passed++;
        checks++;
        if (f < 0 || ld_h[f + 2 * FL + 1] !== 1'b1) $display("FAIL stream_ld2_pos: got %b expected 1", (f < 0) ? 1'bx : ld_h[f + 2 * FL + 1]);
        else passed++;
        checks++;
        if (count_ld() !== 2) $display("FAIL stream_ld_count: got %0d expected 2", count_ld());
        else passed++;
        checks++;
        if (count_overlap() !== 0) $display("FAIL stream_ld_se_overlap: got %0d expected 0", count_overlap());
        else passed++;
    endtask

`ifdef SH_CHAIN_LOADER_PARITY_EN
    task automatic test_parity();
        int f;
        run(8'h01, 8'h00, 8'h00, 8'h00, 2, 0, 40, 0);
        f = first_se();
        checks++;
        if (f < 0 || count_se(f, CL + 1) !== CL + 1) $display("FAIL parity_se_run: got %0d expected %0d", count_se(f, CL + 1), CL + 1);
        else passed++;
        checks++;
        if (f < 0 || sd_h[f + CL] !== 1'b1) $display("FAIL parity_bit: got %b expected 1", (f < 0) ? 1'bx : sd_h[f + CL]);
        else passed++;
        checks++;
        if (f < 0 || ld_h[f + CL + 1] !== 1'b1) $display("FAIL parity_ld_pos: got %b expected 1", (f < 0) ? 1'bx : ld_h[f + CL + 1]);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        repeat (4) @(negedge C);
        test_stall();
        repeat (4) @(negedge C);
        test_reset_midframe();
        repeat (4) @(negedge C);
        test_stream();
`ifdef SH_CHAIN_LOADER_PARITY_EN
        repeat (4) @(negedge C);
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
